// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack for the frontend with optional checkpoint/restore repair.
// Optional feature macro: RAS_CKPT_EN (snapshot registers and restore path).
module ras_ckpt_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            data_i,
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_restore_i,
  output logic                       top_valid_o,
  output logic [VLEN-1:0]            top_ra_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] TP_MAX  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [VLEN-1:0]  ra_q [DEPTH];
  logic [PW-1:0]    tp_q, tp_d, tp_inc, tp_dec;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [VLEN-1:0]  wr_ra;

  // Restore source: snapshot registers when present, inert constants otherwise
  logic             restore_c;
  logic [PW-1:0]    rs_tp;
  logic [CW-1:0]    rs_cnt;
  logic             rs_valid;
  logic [VLEN-1:0]  rs_ra;

`ifdef RAS_CKPT_EN
  logic [PW-1:0]    sv_tp_q, sv_tp_d;
  logic [CW-1:0]    sv_cnt_q, sv_cnt_d;
  logic             sv_valid_q, sv_valid_d;
  logic [VLEN-1:0]  sv_ra_q, sv_ra_d;

  assign restore_c = ckpt_restore_i;
  assign rs_tp     = sv_tp_q;
  assign rs_cnt    = sv_cnt_q;
  assign rs_valid  = sv_valid_q;
  assign rs_ra     = sv_ra_q;

  // Snapshot captures the post-update top state of this cycle
  always_comb begin
    sv_tp_d    = sv_tp_q;
    sv_cnt_d   = sv_cnt_q;
    sv_valid_d = sv_valid_q;
    sv_ra_d    = sv_ra_q;
    if (ckpt_save_i && !flush_i) begin
      sv_tp_d    = tp_d;
      sv_cnt_d   = cnt_d;
      sv_valid_d = valid_d[tp_d];
      sv_ra_d    = (wr_en && (wr_idx == tp_d)) ? wr_ra : ra_q[tp_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sv_tp_q    <= '0;
      sv_cnt_q   <= '0;
      sv_valid_q <= 1'b0;
      sv_ra_q    <= '0;
    end else begin
      sv_tp_q    <= sv_tp_d;
      sv_cnt_q   <= sv_cnt_d;
      sv_valid_q <= sv_valid_d;
      sv_ra_q    <= sv_ra_d;
    end
  end
`else
  logic unused_ckpt;

  assign unused_ckpt = ckpt_save_i ^ ckpt_restore_i;
  assign restore_c   = 1'b0;
  assign rs_tp       = '0;
  assign rs_cnt      = '0;
  assign rs_valid    = 1'b0;
  assign rs_ra       = '0;
`endif

  // Explicit modulo-DEPTH wrap so non-power-of-2 depths work
  assign tp_inc = (tp_q == TP_MAX) ? '0 : tp_q + PW'(1);
  assign tp_dec = (tp_q == '0) ? TP_MAX : tp_q - PW'(1);

  always_comb begin
    valid_d = valid_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    wr_ra   = data_i;
    if (flush_i) begin
      valid_d = '0;
      tp_d    = '0;
      cnt_d   = '0;
    end else if (restore_c) begin
      tp_d           = rs_tp;
      cnt_d          = rs_cnt;
      valid_d[rs_tp] = rs_valid;
      wr_en          = 1'b1;
      wr_idx         = rs_tp;
      wr_ra          = rs_ra;
    end else if (push_i && pop_i) begin
      valid_d[tp_q] = 1'b1;
      wr_en         = 1'b1;
      if (cnt_q == '0) cnt_d = CW'(1);
    end else if (push_i) begin
      tp_d            = tp_inc;
      valid_d[tp_inc] = 1'b1;
      wr_en           = 1'b1;
      wr_idx          = tp_inc;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      valid_d[tp_q] = 1'b0;
      tp_d          = tp_dec;
      cnt_d         = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      tp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address storage needs no reset; outputs are gated by the valid bit
  always_ff @(posedge clk_i) begin
    if (wr_en) ra_q[wr_idx] <= wr_ra;
  end

  assign top_valid_o = valid_q[tp_q] && (cnt_q != '0);
  assign top_ra_o    = top_valid_o ? ra_q[tp_q] : '0;
  assign count_o     = cnt_q;

endmodule
